// File: rtl/serial_parallel_pkg.sv
// serial_parallel_pkg: shared FSM encoding and default comma for the serial deserialiser
package serial_parallel_pkg;
  typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;
  localparam logic [7:0] COMMA_DEF = 8'hBC;
endpackage

// File: rtl/serial_parallel_lane.sv
// serial_parallel_lane: one serial lane with comma alignment, lock tracking and word output
module serial_parallel_lane
  import serial_parallel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] COMMA = DATA_W'(COMMA_DEF),
  parameter int LOCK_CNT = 4,
  parameter int UNLOCK_CNT = 2
) (
  input  logic              clk_32f,
  input  logic              reset_L,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              locked
);
  localparam int BW = $clog2(DATA_W - 1) + 1;
  localparam int CW = $clog2(LOCK_CNT) + 1;
  localparam int ZW = $clog2(UNLOCK_CNT) + 1;
  state_t state;
  logic [DATA_W-1:0] sr, sr_next;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] comma_cnt, comma_inc;
  logic [ZW-1:0] zero_cnt, zero_inc;
  logic boundary, is_comma, is_zero;
  assign sr_next   = {sr[DATA_W-2:0], data_in};
  assign boundary  = bit_cnt == BW'(DATA_W - 1);
  assign is_comma  = sr_next == COMMA;
  assign is_zero   = sr_next == '0;
  assign comma_inc = comma_cnt + 1'b1;
  assign zero_inc  = zero_cnt + 1'b1;
  always_ff @(posedge clk_32f or negedge reset_L)
    if (!reset_L) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      zero_cnt  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      locked    <= 1'b0;
    end else begin
      sr        <= sr_next;
      bit_cnt   <= boundary ? '0 : bit_cnt + 1'b1;
      valid_out <= 1'b0;
      case (state)
        SEARCH: begin
          zero_cnt <= '0;
          if (is_comma) begin
            bit_cnt   <= '0;
            comma_cnt <= CW'(1);
            state     <= (LOCK_CNT == 1) ? LOCKED : ALIGN;
            locked    <= LOCK_CNT == 1;
          end
        end
        ALIGN: if (boundary) begin
          if (is_comma) begin
            comma_cnt <= (comma_cnt == CW'(LOCK_CNT)) ? comma_cnt : comma_inc;
            if (comma_inc == CW'(LOCK_CNT)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else begin
            state     <= SEARCH;
            comma_cnt <= '0;
          end
        end
        LOCKED: if (boundary) begin
          // commas and zero words are fill, never payload
          zero_cnt <= is_zero ? ((zero_cnt == ZW'(UNLOCK_CNT)) ? zero_cnt : zero_inc) : '0;
          if (is_zero && zero_inc == ZW'(UNLOCK_CNT)) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            comma_cnt <= '0;
          end
          if (!is_zero && !is_comma) begin
            data_out  <= sr_next;
            valid_out <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
endmodule

// File: rtl/serial_parallel_multi.sv
// serial_parallel_multi: LANES independent comma-aligned serial-to-parallel deserialisers
module serial_parallel_multi
  import serial_parallel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES = 2,
  parameter logic [DATA_W-1:0] COMMA = DATA_W'(COMMA_DEF),
  parameter int LOCK_CNT = 4,
  parameter int UNLOCK_CNT = 2
) (
  input  logic                    clk_32f,
  input  logic                    reset_L,
  input  logic [LANES-1:0]        data_in,
  output logic [LANES*DATA_W-1:0] data_out,
  output logic [LANES-1:0]        valid_out,
  output logic [LANES-1:0]        locked
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    serial_parallel_lane #(
      .DATA_W(DATA_W), .COMMA(COMMA), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
    ) u_lane (
      .clk_32f  (clk_32f),
      .reset_L  (reset_L),
      .data_in  (data_in[i]),
      .data_out (data_out[i*DATA_W +: DATA_W]),
      .valid_out(valid_out[i]),
      .locked   (locked[i])
    );
  end
endmodule

// File: tb/tb_serial_parallel_multi.sv
// tb_serial_parallel_multi: directed streams with a per-lane scoreboard of expected payload words
module tb_serial_parallel_multi;
  logic clk = 1'b0, reset_L = 1'b0;
  logic [1:0] data_in = '0;
  logic [15:0] data_out;
  logic [1:0] valid_out, locked;
  logic [0:0] d10 = '0;
  logic [9:0] q10;
  logic [0:0] v10, l10;
  int vectors = 0, errors = 0;
  bit bq0[$], bq1[$], bq2[$];
  logic [9:0] eq0[$], eq1[$], eq2[$];

  serial_parallel_multi dut (
    .clk_32f(clk), .reset_L(reset_L), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .locked(locked)
  );
  serial_parallel_multi #(.DATA_W(10), .LANES(1), .COMMA(10'h17C), .LOCK_CNT(1)) u10 (
    .clk_32f(clk), .reset_L(reset_L), .data_in(d10),
    .data_out(q10), .valid_out(v10), .locked(l10)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(int s, logic [9:0] w, int n, bit v);
    for (int b = n - 1; b >= 0; b--)
      if (s == 0) bq0.push_back(w[b]);
      else if (s == 1) bq1.push_back(w[b]);
      else bq2.push_back(w[b]);
    if (v) begin
      if (s == 0) eq0.push_back(w);
      else if (s == 1) eq1.push_back(w);
      else eq2.push_back(w);
    end
  endtask

  task automatic put8(int s, logic [7:0] w, bit v);
    put(s, {2'b00, w}, 8, v);
  endtask

  task automatic run(int n);
    repeat (n) begin
      data_in = '0;
      d10 = '0;
      if (bq0.size() > 0) data_in[0] = bq0.pop_front();
      if (bq1.size() > 0) data_in[1] = bq1.pop_front();
      if (bq2.size() > 0) d10[0] = bq2.pop_front();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic score(int s, logic [9:0] obs);
    logic [9:0] exp;
    if (s == 0 && eq0.size() > 0) exp = eq0.pop_front();
    else if (s == 1 && eq1.size() > 0) exp = eq1.pop_front();
    else if (s == 2 && eq2.size() > 0) exp = eq2.pop_front();
    else begin
      check($sformatf("unexpected valid lane%0d", s), 32'd1, 32'd0);
      return;
    end
    check($sformatf("payload lane%0d", s), 32'(obs), 32'(exp));
  endtask

  always @(negedge clk) begin
    if (valid_out[0]) score(0, {2'b00, data_out[7:0]});
    if (valid_out[1]) score(1, {2'b00, data_out[15:8]});
    if (v10[0]) score(2, q10);
  end

  initial begin
    run(3);
    check("reset data_out", 32'(data_out), 0);
    check("reset valid_out", 32'(valid_out), 0);
    check("reset locked", 32'(locked), 0);
    check("reset w10", 32'({q10, v10, l10}), 0);
    reset_L = 1'b1;
    // lock, payload, dropped comma, unlock on two zero words
    put8(0, 8'hAA, 0);
    repeat (4) put8(0, 8'hBC, 0);
    run(39);
    check("lock before 4th comma", 32'(locked), 0);
    run(1);
    check("lock on 4th comma", 32'(locked), 2'b01);
    put8(0, 8'hBB, 1); put8(0, 8'hCC, 1); put8(0, 8'hDD, 1); put8(0, 8'hEE, 1);
    put8(0, 8'hBC, 0); put8(0, 8'hFF, 1); put8(0, 8'h00, 0); put8(0, 8'h00, 0);
    run(32);
    check("valid on EE", 32'(valid_out), 2'b01);
    check("data EE", 32'(data_out[7:0]), 8'hEE);
    run(8);
    check("comma dropped valid", 32'(valid_out), 0);
    check("comma dropped data", 32'(data_out[7:0]), 8'hEE);
    run(16);
    check("locked after one zero", 32'(locked), 2'b01);
    run(8);
    check("unlock after two zeros", 32'(locked), 0);
    check("data holds FF", 32'(data_out[7:0]), 8'hFF);
    // broken comma run restarts the search
    put8(0, 8'hAA, 0);
    repeat (3) put8(0, 8'hBC, 0);
    put8(0, 8'h55, 0);
    repeat (4) put8(0, 8'hBC, 0);
    put8(0, 8'h12, 1);
    run(40);
    check("no lock after 3 commas", 32'(locked), 0);
    run(32);
    check("lock after fresh 4 commas", 32'(locked), 2'b01);
    run(8);
    check("data 12", 32'(data_out[7:0]), 8'h12);
    put8(0, 8'h00, 0); put8(0, 8'h00, 0);
    run(16);
    check("unlock seg2", 32'(locked), 0);
    // comma on a shifted boundary
    put(0, 10'b101, 3, 0);
    repeat (4) put8(0, 8'hBC, 0);
    put8(0, 8'hA5, 1);
    run(35);
    check("lock shifted", 32'(locked), 2'b01);
    run(8);
    check("data A5", 32'(data_out[7:0]), 8'hA5);
    put8(0, 8'h00, 0); put8(0, 8'h00, 0);
    run(16);
    check("unlock seg3", 32'(locked), 0);
    // lane 1 sees the same stream 5 bits later
    put(1, 10'd0, 5, 0);
    for (int s = 0; s < 2; s++) begin
      repeat (4) put8(s, 8'hBC, 0);
      put8(s, 8'h3C, 1);
      put8(s, 8'h81, 1);
    end
    run(39);
    check("skew pre valid", 32'(valid_out), 0);
    run(1);
    check("skew lane0 valid", 32'(valid_out), 2'b01);
    check("skew lane0 data", 32'(data_out[7:0]), 8'h3C);
    run(4);
    check("skew gap", 32'(valid_out), 0);
    check("skew both locked", 32'(locked), 2'b11);
    run(1);
    check("skew lane1 valid", 32'(valid_out), 2'b10);
    check("skew lane1 data", 32'(data_out[15:8]), 8'h3C);
    run(8);
    check("skew lane1 81", 32'(valid_out), 2'b10);
    check("skew data 81", 32'(data_out), 16'h8181);
    put8(0, 8'h00, 0); put8(0, 8'h00, 0); put8(1, 8'h00, 0); put8(1, 8'h00, 0);
    run(16);
    check("unlock both", 32'(locked), 0);
    // reset mid-word while locked
    repeat (4) put8(0, 8'hBC, 0);
    put8(0, 8'h77, 1);
    run(40);
    check("data 77", 32'(data_out[7:0]), 8'h77);
    put8(0, 8'hF0, 0);
    run(4);
    #2 reset_L = 1'b0;
    #1;
    check("async reset data", 32'(data_out), 0);
    check("async reset locked", 32'(locked), 0);
    bq0.delete();
    run(2);
    reset_L = 1'b1;
    repeat (3) put8(0, 8'hBC, 0);
    put8(0, 8'h66, 0);
    run(32);
    check("no relock after 3", 32'(locked), 0);
    repeat (4) put8(0, 8'hBC, 0);
    put8(0, 8'h99, 1);
    run(32);
    check("relock after reset", 32'(locked), 2'b01);
    run(8);
    check("data 99", 32'(data_out[7:0]), 8'h99);
    put8(0, 8'h00, 0); put8(0, 8'h00, 0);
    run(16);
    // 10-bit lane locking on a single comma
    put(2, 10'h17C, 10, 0);
    put(2, 10'h2A5, 10, 1);
    run(9);
    check("w10 pre lock", 32'(l10), 0);
    run(1);
    check("w10 lock", 32'(l10), 1);
    run(10);
    check("w10 valid", 32'(v10), 1);
    check("w10 data", 32'(q10), 10'h2A5);
    run(4);
    check("scoreboard drained", 32'(eq0.size() + eq1.size() + eq2.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
